// File: rtl/gb_timer_if.sv
// CPU system-bus signals between the CPU (master) and the gb_timer responder (slave).
// Includes the timer interrupt request line towards the interrupt controller.
interface gb_timer_if;
    logic [1:0]  t_cycle;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_select;
    logic        irq_timer;

    modport master (
        output t_cycle, mem_addr, mem_enable, mem_write, mem_wdata,
        input  mem_rdata, mem_select, irq_timer
    );

    modport slave (
        input  t_cycle, mem_addr, mem_enable, mem_write, mem_wdata,
        output mem_rdata, mem_select, irq_timer
    );
endinterface

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer peripheral with a one-clock timer interrupt pulse.
// Define GB_TIMER_OVERFLOW_DELAY_EN for the 4-clock overflow delay with cancel/bypass window.
module gb_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input logic       clk,
    input logic       reset_n,
    gb_timer_if.slave bus
);

`ifdef GB_TIMER_OVERFLOW_DELAY_EN
    typedef enum logic [1:0] {StIdle, StDelay, StReload} state_e;
    state_e     state_q, state_d;
    logic [1:0] dly_cnt_q, dly_cnt_d;
`endif

    logic [15:0] sys_cnt_q, sys_cnt_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        tap_prev_q, tap_prev_d;
    logic        irq_q, irq_d;

    logic [15:0] offset;
    logic        hit;
    logic        commit;
    logic        wr_div, wr_tima, wr_tma, wr_tac;
    logic        tap_bit, tap, tap_fall;

    // Offset decode keeps the window correct for any BASE_ADDR alignment.
    assign offset  = bus.mem_addr - BASE_ADDR;
    assign hit     = (offset[15:2] == 14'd0);
    assign commit  = bus.mem_enable & bus.mem_write & hit & (bus.t_cycle == 2'd3);
    assign wr_div  = commit & (offset[1:0] == 2'd0);
    assign wr_tima = commit & (offset[1:0] == 2'd1);
    assign wr_tma  = commit & (offset[1:0] == 2'd2);
    assign wr_tac  = commit & (offset[1:0] == 2'd3);

    assign bus.mem_select = hit;
    assign bus.irq_timer  = irq_q;

    always_comb begin
        bus.mem_rdata = 8'hFF;
        if (hit) begin
            unique case (offset[1:0])
                2'd0: bus.mem_rdata = sys_cnt_q[15:8];
                2'd1: bus.mem_rdata = tima_q;
                2'd2: bus.mem_rdata = tma_q;
                2'd3: bus.mem_rdata = {5'b11111, tac_q};
            endcase
        end
    end

    always_comb begin
        unique case (tac_q[1:0])
            2'b00: tap_bit = sys_cnt_q[9];
            2'b01: tap_bit = sys_cnt_q[3];
            2'b10: tap_bit = sys_cnt_q[5];
            2'b11: tap_bit = sys_cnt_q[7];
        endcase
    end

    // Falls caused by DIV clears or TAC rewrites count too, as on the real chip.
    assign tap      = tac_q[2] & tap_bit;
    assign tap_fall = tap_prev_q & ~tap;

    always_comb begin
        sys_cnt_d  = wr_div ? 16'h0000 : sys_cnt_q + 16'd1;
        tac_d      = wr_tac ? bus.mem_wdata[2:0] : tac_q;
        tma_d      = wr_tma ? bus.mem_wdata : tma_q;
        tap_prev_d = tap;
        tima_d     = tima_q;
        irq_d      = 1'b0;
`ifdef GB_TIMER_OVERFLOW_DELAY_EN
        state_d    = state_q;
        dly_cnt_d  = dly_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (wr_tima) begin
                    tima_d = bus.mem_wdata;
                end else if (tap_fall) begin
                    if (tima_q == 8'hFF) begin
                        tima_d    = 8'h00;
                        state_d   = StDelay;
                        dly_cnt_d = 2'd3;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            StDelay: begin
                dly_cnt_d = dly_cnt_q - 2'd1;
                if (wr_tima) begin
                    tima_d  = bus.mem_wdata;
                    state_d = StIdle;
                end else if (dly_cnt_q == 2'd0) begin
                    tima_d  = tma_d;
                    irq_d   = 1'b1;
                    state_d = StReload;
                end else if (tap_fall) begin
                    tima_d = tima_q + 8'd1;
                end
            end
            StReload: begin
                // TIMA writes lose here; a TMA write in this clock still lands in TIMA.
                tima_d  = tma_d;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
`else
        if (wr_tima) begin
            tima_d = bus.mem_wdata;
        end else if (tap_fall) begin
            if (tima_q == 8'hFF) begin
                tima_d = tma_d;
                irq_d  = 1'b1;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sys_cnt_q  <= 16'h0000;
            tima_q     <= 8'h00;
            tma_q      <= 8'h00;
            tac_q      <= 3'b000;
            tap_prev_q <= 1'b0;
            irq_q      <= 1'b0;
`ifdef GB_TIMER_OVERFLOW_DELAY_EN
            state_q    <= StIdle;
            dly_cnt_q  <= 2'd0;
`endif
        end else begin
            sys_cnt_q  <= sys_cnt_d;
            tima_q     <= tima_d;
            tma_q      <= tma_d;
            tac_q      <= tac_d;
            tap_prev_q <= tap_prev_d;
            irq_q      <= irq_d;
`ifdef GB_TIMER_OVERFLOW_DELAY_EN
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
`endif
        end
    end

endmodule
